dvp_frame_gen: RTL and testbench

DVP_FRAME_GEN -- requirements
Module: dvp_frame_gen

---
 rtl/dvp_frame_gen.sv | 215 +++++++++++++++++++++
 tb/tb_dvp_frame_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_gen.sv
// rtl/dvp_frame_gen.sv - DVP camera frame timing and test-pattern generator
//
// Ports:
//   sys_clk       sole clock
//   rst           synchronous active-high reset
//   pclk_en       beat enable; all timing advances only on enabled cycles
//   start_i       start request (honoured only while idle)
//   stop_i        finish the current frame, then return to idle
//   cont_i        continuous mode, sampled at each frame start
//   mode_i        data pattern select, sampled at each frame start
//   dvp_d_o       pixel data, 0 outside href
//   dvp_href_o    line-valid
//   dvp_vsync_o   frame sync, active high
//   dvp_hsync_o   line sync, active-low pulse
//   busy_o        frame in progress
//   frame_done_o  one-cycle end-of-frame pulse
//   frame_cnt_o   completed-frame count, wraps at 16 bits

module dvp_frame_gen #(
  parameter int                DATA_W        = 8,
  parameter int                H_ACTIVE      = 640,
  parameter int                BYTES_PER_PIX = 2,
  parameter int                V_ACTIVE      = 480,
  parameter int                VSYNC_CYC     = 4704,
  parameter int                VBP_CYC       = 20978,
  parameter int                HS_PRE_CYC    = 38,
  parameter int                HS_LOW_CYC    = 160,
  parameter int                HBP_CYC       = 80,
  parameter int                VFP_CYC       = 15402,
  parameter logic [DATA_W-1:0] CONST_VAL     = 8'hA5,
  parameter int                CNT_W         = 24
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              pclk_en,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              cont_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] dvp_d_o,
  output logic              dvp_href_o,
  output logic              dvp_vsync_o,
  output logic              dvp_hsync_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int LINE_BEATS = H_ACTIVE * BYTES_PER_PIX;

  // Terminal values of the per-state beat counter.
  localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(VSYNC_CYC - 1);
  localparam logic [CNT_W-1:0] VBP_LAST    = CNT_W'(VBP_CYC - 1);
  localparam logic [CNT_W-1:0] HPRE_LAST   = CNT_W'(HS_PRE_CYC - 1);
  localparam logic [CNT_W-1:0] HSLOW_LAST  = CNT_W'(HS_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HBP_LAST    = CNT_W'(HBP_CYC - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0] VFP_LAST    = CNT_W'(VFP_CYC - 1);
  localparam logic [CNT_W-1:0] LINE_LAST   = CNT_W'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    IDLE, VSYNC, VBP, HPRE, HSLOW, HBP, ACTIVE, VFP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;        // beats spent in the current state
  logic [CNT_W-1:0] beat;       // active beats already emitted this frame
  logic [CNT_W-1:0] line;       // current active line
  logic [1:0]       mode_r;
  logic             cont_r;
  logic             stop_pend;
  logic [CNT_W-1:0] state_last;
  logic             last;

  always_comb begin
    state_last = '0;
    case (state)
      VSYNC:   state_last = VSYNC_LAST;
      VBP:     state_last = VBP_LAST;
      HPRE:    state_last = HPRE_LAST;
      HSLOW:   state_last = HSLOW_LAST;
      HBP:     state_last = HBP_LAST;
      ACTIVE:  state_last = ACTIVE_LAST;
      VFP:     state_last = VFP_LAST;
      default: state_last = '0;
    endcase
  end

  assign last = (cnt == state_last);

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]       m,
                                                input logic [CNT_W-1:0] b,
                                                input logic [CNT_W-1:0] col,
                                                input logic [CNT_W-1:0] l);
    case (m)
      2'd0:    return DATA_W'(b & CNT_W'(31));
      2'd1:    return DATA_W'(b);
      2'd2:    return CONST_VAL;
      default: return DATA_W'(col ^ l);
    endcase
  endfunction

  // Outputs are loaded from the state being entered, so they line up with
  // the state that the next cycle shows.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      beat         <= '0;
      line         <= '0;
      mode_r       <= 2'd0;
      cont_r       <= 1'b0;
      stop_pend    <= 1'b0;
      dvp_d_o      <= '0;
      dvp_href_o   <= 1'b0;
      dvp_vsync_o  <= 1'b0;
      dvp_hsync_o  <= 1'b1;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= 16'd0;
    end else begin
      frame_done_o <= 1'b0;
      // A stop request is remembered even on disabled beats.
      if (busy_o && stop_i) stop_pend <= 1'b1;
      if (pclk_en) begin
        case (state)
          IDLE: begin
            if (start_i) begin
              state       <= VSYNC;
              cnt         <= '0;
              beat        <= '0;
              line        <= '0;
              mode_r      <= mode_i;
              cont_r      <= cont_i;
              stop_pend   <= stop_i;
              dvp_vsync_o <= 1'b1;
              busy_o      <= 1'b1;
            end
          end
          VSYNC: begin
            if (last) begin
              state       <= VBP;
              cnt         <= '0;
              dvp_vsync_o <= 1'b0;
            end else cnt <= cnt + CNT_W'(1);
          end
          VBP: begin
            if (last) begin
              state <= HPRE;
              cnt   <= '0;
            end else cnt <= cnt + CNT_W'(1);
          end
          HPRE: begin
            if (last) begin
              state       <= HSLOW;
              cnt         <= '0;
              dvp_hsync_o <= 1'b0;
            end else cnt <= cnt + CNT_W'(1);
          end
          HSLOW: begin
            if (last) begin
              state       <= HBP;
              cnt         <= '0;
              dvp_hsync_o <= 1'b1;
            end else cnt <= cnt + CNT_W'(1);
          end
          HBP: begin
            if (last) begin
              state      <= ACTIVE;
              cnt        <= '0;
              dvp_href_o <= 1'b1;
              dvp_d_o    <= pattern(mode_r, beat, '0, line);
              beat       <= beat + CNT_W'(1);
            end else cnt <= cnt + CNT_W'(1);
          end
          ACTIVE: begin
            if (last) begin
              cnt        <= '0;
              dvp_href_o <= 1'b0;
              dvp_d_o    <= '0;
              line       <= line + CNT_W'(1);
              state      <= (line == LINE_LAST) ? VFP : HPRE;
            end else begin
              cnt     <= cnt + CNT_W'(1);
              dvp_d_o <= pattern(mode_r, beat, cnt + CNT_W'(1), line);
              beat    <= beat + CNT_W'(1);
            end
          end
          VFP: begin
            if (last) begin
              cnt          <= '0;
              frame_done_o <= 1'b1;
              frame_cnt_o  <= frame_cnt_o + 16'd1;
              // A stop arriving on this very beat still ends the run here.
              if (cont_r && !(stop_pend || stop_i)) begin
                state       <= VSYNC;
                beat        <= '0;
                line        <= '0;
                mode_r      <= mode_i;
                cont_r      <= cont_i;
                dvp_vsync_o <= 1'b1;
              end else begin
                state     <= IDLE;
                busy_o    <= 1'b0;
                stop_pend <= 1'b0;
              end
            end else cnt <= cnt + CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dvp_frame_gen.sv
// tb/tb_dvp_frame_gen.sv - self-checking bench for dvp_frame_gen
//
// Drives the generator with a reduced frame geometry (31 beats per frame)
// and compares every cycle against a position-in-frame reference model.

module tb_dvp_frame_gen;

  // Frame geometry, in enabled beats.
  localparam int VS    = 3;
  localparam int VB    = 2;
  localparam int HP    = 1;
  localparam int HL    = 2;
  localparam int HB    = 1;
  localparam int LB    = 8;  // 4 pixels x 2 beats
  localparam int NL    = 2;
  localparam int VF    = 2;
  localparam int LINE  = HP + HL + HB + LB;
  localparam int FRAME = VS + VB + NL * LINE + VF;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        pclk_en = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        cont_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [7:0]  dvp_d_o;
  logic        dvp_href_o;
  logic        dvp_vsync_o;
  logic        dvp_hsync_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [15:0] frame_cnt_o;

  dvp_frame_gen #(
    .DATA_W(8), .H_ACTIVE(4), .BYTES_PER_PIX(2), .V_ACTIVE(NL),
    .VSYNC_CYC(VS), .VBP_CYC(VB), .HS_PRE_CYC(HP), .HS_LOW_CYC(HL),
    .HBP_CYC(HB), .VFP_CYC(VF), .CONST_VAL(8'hA5), .CNT_W(24)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .pclk_en(pclk_en), .start_i(start_i),
    .stop_i(stop_i), .cont_i(cont_i), .mode_i(mode_i), .dvp_d_o(dvp_d_o),
    .dvp_href_o(dvp_href_o), .dvp_vsync_o(dvp_vsync_o),
    .dvp_hsync_o(dvp_hsync_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: whether a frame runs, and which beat of it is showing.
  bit          m_busy = 1'b0;
  bit          m_cont = 1'b0;
  bit          m_stop = 1'b0;
  bit          m_done = 1'b0;
  int          m_p = 0;
  int          m_mode = 0;
  logic [15:0] m_cnt = 16'd0;

  logic [7:0] hq[$];
  int         n_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pat(input int mode, input int b, input int col, input int l);
    case (mode)
      0:       return 8'(b % 32);
      1:       return 8'(b);
      2:       return 8'hA5;
      default: return 8'(col ^ l);
    endcase
  endfunction

  function automatic logic [31:0] exp_vec();
    logic       vs = 1'b0;
    logic       hs = 1'b1;
    logic       hr = 1'b0;
    logic [7:0] d  = 8'd0;
    if (m_busy) begin
      if (m_p < VS) vs = 1'b1;
      else if (m_p >= VS + VB && m_p < VS + VB + NL * LINE) begin
        int q = m_p - VS - VB;
        int l = q / LINE;
        int r = q % LINE;
        if (r >= HP && r < HP + HL) hs = 1'b0;
        if (r >= HP + HL + HB) begin
          int col = r - (HP + HL + HB);
          hr = 1'b1;
          d  = pat(m_mode, l * LB + col, col, l);
        end
      end
    end
    return {3'b0, vs, hs, hr, m_busy, m_done, m_cnt, d};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {3'b0, dvp_vsync_o, dvp_hsync_o, dvp_href_o, busy_o, frame_done_o,
            frame_cnt_o, dvp_d_o};
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all outputs just after the edge.
  task automatic tick(input string tag);
    @(posedge sys_clk);
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_stop = 1'b0; m_cnt = 16'd0; m_p = 0;
    end else begin
      if (m_busy && stop_i) m_stop = 1'b1;
      if (pclk_en) begin
        if (!m_busy) begin
          if (start_i) begin
            m_busy = 1'b1; m_p = 0; m_mode = int'(mode_i);
            m_cont = cont_i; m_stop = stop_i;
          end
        end else if (m_p == FRAME - 1) begin
          m_done = 1'b1;
          m_cnt  = m_cnt + 16'd1;
          if (m_cont && !m_stop) begin
            m_p = 0; m_mode = int'(mode_i); m_cont = cont_i;
          end else begin
            m_busy = 1'b0; m_stop = 1'b0;
          end
        end else m_p++;
      end
    end
    #1;
    chk(tag, dut_vec(), exp_vec());
    if (dvp_href_o) hq.push_back(dvp_d_o);
    if (frame_done_o) n_done++;
  endtask

  initial begin
    logic [7:0] line1_m3 [8];
    int a5_cnt;
    line1_m3 = '{8'd1, 8'd0, 8'd3, 8'd2, 8'd5, 8'd4, 8'd7, 8'd6};

    // Reset, with the beat enable both low and high.
    rst = 1'b1; pclk_en = 1'b0;
    tick("reset_en0");
    pclk_en = 1'b1;
    tick("reset_en1");
    rst = 1'b0;
    tick("idle");

    // Single frame, mode 0, enable always high.
    mode_i = 2'd0; cont_i = 1'b0; start_i = 1'b1;
    tick("a_start");
    start_i = 1'b0; hq.delete(); n_done = 0;
    repeat (FRAME + 2) tick("a_run");
    chk("a_href_beats", hq.size(), 32'd16);
    for (int i = 0; i < 16 && i < hq.size(); i++) chk("a_data", hq[i], i);
    chk("a_done_pulses", n_done, 32'd1);
    chk("a_frame_cnt", frame_cnt_o, 32'd1);
    chk("a_busy", busy_o, 32'd0);

    // Same frame at half rate, mode 1.
    mode_i = 2'd1; start_i = 1'b1; pclk_en = 1'b1;
    tick("b_start");
    start_i = 1'b0; n_done = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      pclk_en = (i % 2 == 1);
      tick("b_run");
    end
    chk("b_done_pulses", n_done, 32'd1);
    chk("b_frame_cnt", frame_cnt_o, 32'd2);

    // Continuous mode 3, stop requested during the second frame.
    pclk_en = 1'b1; mode_i = 2'd3; cont_i = 1'b1; start_i = 1'b1;
    tick("c_start");
    start_i = 1'b0; hq.delete(); n_done = 0;
    mode_i = 2'd0;  // must not affect the running frame
    for (int k = 1; k <= 4 * FRAME; k++) begin
      if (k == 20) mode_i = 2'd3;
      stop_i = (k == 40);
      tick("c_run");
      if (k > 40 && !busy_o) break;
    end
    stop_i = 1'b0;
    chk("c_idle", busy_o, 32'd0);
    chk("c_done_pulses", n_done, 32'd2);
    for (int i = 0; i < 8 && i + 8 < hq.size(); i++) chk("c_line1", hq[i + 8], line1_m3[i]);

    // Reset during the active part of the second line.
    cont_i = 1'b0; mode_i = 2'($urandom_range(0, 3)); start_i = 1'b1;
    tick("d_start");
    start_i = 1'b0; n_done = 0;
    for (int k = 0; k < FRAME && m_p != VS + VB + LINE + HP + HL + HB + 2; k++) tick("d_run");
    chk("d_reached_line1", m_p, VS + VB + LINE + HP + HL + HB + 2);
    rst = 1'b1;
    tick("d_reset");
    rst = 1'b0;
    tick("d_idle");
    chk("d_no_done", n_done, 32'd0);
    start_i = 1'b1;
    tick("d_restart");
    start_i = 1'b0;
    repeat (FRAME + 2) tick("d_run2");
    chk("d_done_pulses", n_done, 32'd1);
    chk("d_frame_cnt", frame_cnt_o, 32'd1);

    // Counter wrap from a preset value, start ignored while busy, mode 2.
    pclk_en = 1'b0;
    force dut.frame_cnt_o = 16'hFFFE;
    @(posedge sys_clk); #1;
    release dut.frame_cnt_o;
    m_cnt = 16'hFFFE;
    tick("e_preset");
    pclk_en = 1'b1; mode_i = 2'd2; cont_i = 1'b1; start_i = 1'b1;
    tick("e_start");
    start_i = 1'b0; hq.delete(); n_done = 0;
    for (int k = 1; k <= 2 * FRAME + 3; k++) begin
      start_i = (k >= 10 && k <= 12) || (k >= 40 && k <= 41);
      if (k == 5) cont_i = 1'b0;
      tick("e_run");
    end
    start_i = 1'b0;
    chk("e_done_pulses", n_done, 32'd2);
    chk("e_wrap", frame_cnt_o, 32'd0);
    chk("e_busy", busy_o, 32'd0);
    a5_cnt = 0;
    foreach (hq[i]) if (hq[i] == 8'hA5) a5_cnt++;
    chk("e_a5_beats", a5_cnt, 32'd32);

    // Random enable, requests, modes and occasional reset.
    for (int k = 0; k < 1500; k++) begin
      pclk_en = ($urandom_range(0, 3) != 0);
      start_i = ($urandom_range(0, 15) == 0);
      stop_i  = ($urandom_range(0, 60) == 0);
      cont_i  = 1'($urandom_range(0, 1));
      mode_i  = 2'($urandom_range(0, 3));
      rst     = ($urandom_range(0, 400) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
